// File: rtl/sw_hw_mailbox.sv
// Software-to-hardware mailbox: a four-phase command handshake on the software side
// feeds a DEPTH-entry frame FIFO drained by a valid/ready hardware consumer.
module sw_hw_mailbox #(
    parameter int NUM_CH = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [NUM_CH*DATA_W-1:0]   sw_port_data,
    input  logic [1:0]                 sw_sig,
    output logic [1:0]                 sw_ack,
    output logic [NUM_CH*DATA_W-1:0]   hw_data,
    output logic                       hw_valid,
    input  logic                       hw_ready,
    output logic [$clog2(DEPTH):0]     hw_level,
    output logic [1:0]                 fsm_state
);
    localparam int FRAME_W = NUM_CH * DATA_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;

    localparam logic [1:0] WAIT_REL = 2'd0;
    localparam logic [1:0] IDLE     = 2'd1;
    localparam logic [1:0] ACK      = 2'd2;

    localparam logic [1:0] SIG_IDLE   = 2'b00;
    localparam logic [1:0] SIG_COMMIT = 2'b01;
    localparam logic [1:0] SIG_FLUSH  = 2'b10;

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [1:0]         sig_q;
    logic               sig_seen;
    logic [1:0]         state;
    logic [1:0]         ack;

    logic full;
    logic commit_req;
    logic flush_req;
    logic push;
    logic pop;

    // Consumer handshake: a frame transfers on every rising edge where hw_valid
    // and hw_ready are both high; hw_data is held stable until that edge.
    assign full       = (level == LVL_W'(DEPTH));
    assign commit_req = (state == IDLE) && (sig_q == SIG_COMMIT);
    assign flush_req  = (state == IDLE) && (sig_q == SIG_FLUSH);
    assign push       = commit_req && !full;
    assign pop        = hw_valid && hw_ready;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sig_q    <= SIG_IDLE;
            sig_seen <= 1'b0;
            state    <= WAIT_REL;
            ack      <= 2'b00;
        end else begin
            sig_q    <= sw_sig;
            sig_seen <= 1'b1;
            case (state)
                // The reset value of sig_q is not a release: wait for a
                // genuinely sampled idle command before accepting new ones.
                WAIT_REL: begin
                    ack <= 2'b00;
                    if (sig_seen && sig_q == SIG_IDLE) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (sig_q == SIG_COMMIT) begin
                        ack   <= full ? 2'b11 : 2'b01;
                        state <= ACK;
                    end else if (sig_q == SIG_FLUSH) begin
                        ack   <= 2'b01;
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (sig_q == SIG_IDLE) begin
                        ack   <= 2'b00;
                        state <= IDLE;
                    end
                end
                default: begin
                    ack   <= 2'b00;
                    state <= WAIT_REL;
                end
            endcase
        end
    end

    // Flush outranks a same-edge pop; full is judged on the pre-edge level.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || flush_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset && push) begin
            mem[wr_ptr] <= sw_port_data;
        end
    end

    assign hw_data   = mem[rd_ptr];
    assign hw_valid  = (level != '0);
    assign hw_level  = level;
    assign sw_ack    = ack;
    assign fsm_state = state;

endmodule
